// File: rtl/ptw_arbiter.sv
// Round-robin arbiter sharing one page-table walker between NUM_REQ TLB clients.
// A grant is held until the PTW accepts it; the response is routed to the owning client only.
package mmu_pkg;
   typedef struct packed {
      logic        valid;
      logic [26:0] vpn;
      logic [8:0]  asid;
      logic [1:0]  prv;
      logic        store;
      logic        fetch;
   } ptw_req_t;

   typedef struct packed {
      logic        valid;
      logic        error;
      logic [31:0] pte;
   } ptw_resp_t;

   typedef struct packed {
      ptw_req_t req;
   } tlb_ptw_comm_t;

   typedef struct packed {
      logic       ptw_ready;
      ptw_resp_t  resp;
      logic       invalidate_tlb;
      logic [3:0] ptw_status;
   } ptw_tlb_comm_t;

   localparam int TLB_PTW_W = $bits(tlb_ptw_comm_t);
   localparam int PTW_TLB_W = $bits(ptw_tlb_comm_t);
endpackage

module ptw_arbiter
   import mmu_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int REQ_IDX_SIZE = $clog2(NUM_REQ)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [NUM_REQ-1:0][TLB_PTW_W-1:0]     tlb_ptw_comm_i,
   output logic [NUM_REQ-1:0][PTW_TLB_W-1:0]     ptw_tlb_comm_o,
   output logic [TLB_PTW_W-1:0]                  tlb_ptw_comm_o,
   input  logic [PTW_TLB_W-1:0]                  ptw_tlb_comm_i,
   output logic [REQ_IDX_SIZE-1:0]               owner_o,
   output logic                                  busy_o,
   output logic                                  orphan_resp_o
);

   typedef enum logic [1:0] {IDLE, GRANTED, WAIT} state_t;

   state_t                  state_reg;
   logic [REQ_IDX_SIZE-1:0] rr_ptr_reg;
   logic [REQ_IDX_SIZE-1:0] grant_reg;
   logic [REQ_IDX_SIZE-1:0] owner_reg;
   logic                    lock_reg;
   logic                    busy_reg;

   ptw_tlb_comm_t           ptw_in;
   tlb_ptw_comm_t           cli_req [NUM_REQ];
   logic [NUM_REQ-1:0]      cli_valid;
   logic                    sel_found;
   logic [REQ_IDX_SIZE-1:0] sel_idx;
   logic [REQ_IDX_SIZE-1:0] cur_idx;
   logic                    cur_valid;
   logic                    fwd;
   logic                    accept;
   logic                    resp_live;

   assign ptw_in = ptw_tlb_comm_i;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cli_in
         assign cli_req[gi]   = tlb_ptw_comm_i[gi];
         assign cli_valid[gi] = cli_req[gi].req.valid;
      end
   endgenerate

   // Scan downward so the candidate closest to rr_ptr is the one left standing.
   always_comb begin
      int                      cand;
      logic [REQ_IDX_SIZE-1:0] cand_idx;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = int'(rr_ptr_reg) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_idx = REQ_IDX_SIZE'(cand);
         if (cli_valid[cand_idx]) begin
            sel_found = 1'b1;
            sel_idx   = cand_idx;
         end
      end
   end

   assign cur_idx   = lock_reg ? grant_reg : sel_idx;
   assign cur_valid = lock_reg ? cli_valid[grant_reg] : sel_found;
   assign fwd       = !rst_i && (state_reg != WAIT) && cur_valid;
   assign accept    = fwd && ptw_in.ptw_ready;
   assign resp_live = !rst_i && (state_reg == WAIT);

   assign tlb_ptw_comm_o = fwd ? cli_req[cur_idx] : '0;
   assign orphan_resp_o  = !rst_i && (state_reg != WAIT) && ptw_in.resp.valid;
   assign owner_o        = owner_reg;
   assign busy_o         = busy_reg;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cli_out
         ptw_tlb_comm_t view;
         always_comb begin
            view                = '0;
            view.invalidate_tlb = ptw_in.invalidate_tlb;
            view.ptw_status     = ptw_in.ptw_status;
            view.ptw_ready      = fwd && ptw_in.ptw_ready && (cur_idx == REQ_IDX_SIZE'(gi));
            if (resp_live && (owner_reg == REQ_IDX_SIZE'(gi))) view.resp = ptw_in.resp;
         end
         assign ptw_tlb_comm_o[gi] = view;
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg  <= IDLE;
         rr_ptr_reg <= '0;
         grant_reg  <= '0;
         owner_reg  <= '0;
         lock_reg   <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  state_reg <= WAIT;
                  owner_reg <= cur_idx;
                  busy_reg  <= 1'b1;
               end else if (fwd) begin
                  state_reg <= GRANTED;
                  grant_reg <= cur_idx;
                  lock_reg  <= 1'b1;
               end
            end
            GRANTED: begin
               // A locked client that withdraws its request releases the lock without moving rr_ptr.
               if (!fwd) begin
                  state_reg <= IDLE;
                  lock_reg  <= 1'b0;
               end else if (accept) begin
                  state_reg <= WAIT;
                  owner_reg <= grant_reg;
                  lock_reg  <= 1'b0;
                  busy_reg  <= 1'b1;
               end
            end
            WAIT: begin
               if (ptw_in.resp.valid) begin
                  state_reg  <= IDLE;
                  busy_reg   <= 1'b0;
                  rr_ptr_reg <= (owner_reg == REQ_IDX_SIZE'(NUM_REQ - 1)) ? '0
                                                                           : owner_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               lock_reg  <= 1'b0;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ptw_arbiter.sv
// Directed bench for ptw_arbiter: stimulus queues expected accepts/responses/orphans,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_ptw_arbiter;
   import mmu_pkg::*;

   localparam int NR = 2;
   localparam int EV_ACC = 0;
   localparam int EV_RESP = 1;
   localparam int EV_ORPH = 2;

   typedef struct {
      int          kind;
      int          cli;
      logic [31:0] data;
   } ev_t;

   logic                     clk;
   logic                     rst_i;
   tlb_ptw_comm_t [NR-1:0]   req_vec;
   ptw_tlb_comm_t [NR-1:0]   cli_view;
   tlb_ptw_comm_t            fwd_out;
   ptw_tlb_comm_t            ptw_in;
   logic                     owner;
   logic                     busy;
   logic                     orphan;

   ev_t sb_q[$];
   int  total = 0;
   int  bad = 0;

   ptw_arbiter #(.NUM_REQ(NR)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .tlb_ptw_comm_i (req_vec),
      .ptw_tlb_comm_o (cli_view),
      .tlb_ptw_comm_o (fwd_out),
      .ptw_tlb_comm_i (ptw_in),
      .owner_o        (owner),
      .busy_o         (busy),
      .orphan_resp_o  (orphan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic push(input int k, input int c, input logic [31:0] d);
      ev_t e;
      e.kind = k;
      e.cli  = c;
      e.data = d;
      sb_q.push_back(e);
   endtask

   task automatic expect_ev(input string name, input int k, input int c, input logic [31:0] d);
      ev_t e;
      if (sb_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: unexpected event cli=%0d data=%0h, required none", name, c, d);
      end else begin
         e = sb_q.pop_front();
         $display("txn %s cli=%0d data=%0h", name, c, d);
         chk({name, "_kind"}, 64'(k), 64'(e.kind));
         chk({name, "_cli"}, 64'(c), 64'(e.cli));
         chk({name, "_data"}, 64'(d), 64'(e.data));
      end
   endtask

   always @(negedge clk) begin
      int who;
      if (!rst_i) begin
         if (fwd_out.req.valid && ptw_in.ptw_ready) begin
            who = -1;
            for (int i = 0; i < NR; i++) if (cli_view[i].ptw_ready) who = i;
            expect_ev("accept", EV_ACC, who, 32'(fwd_out.req.vpn));
         end
         for (int i = 0; i < NR; i++)
            if (cli_view[i].resp.valid) expect_ev("resp", EV_RESP, i, cli_view[i].resp.pte);
         if (orphan) expect_ev("orphan", EV_ORPH, 0, 32'h0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int c, input logic v, input logic [26:0] vpn);
      req_vec[c].req.valid = v;
      req_vec[c].req.vpn   = vpn;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with a pending request and live broadcast fields.
      rst_i   = 1'b1;
      req_vec = '0;
      ptw_in  = '0;
      set_req(0, 1'b1, 27'h7);
      ptw_in.ptw_ready      = 1'b1;
      ptw_in.invalidate_tlb = 1'b1;
      ptw_in.ptw_status     = 4'h5;
      tick();
      @(negedge clk);
      chk("rst_fwd_valid", 64'(fwd_out.req.valid), 0);
      chk("rst_ready_c0", 64'(cli_view[0].ptw_ready), 0);
      chk("rst_inval_bcast", 64'(cli_view[1].invalidate_tlb), 1);
      chk("rst_status_bcast", 64'(cli_view[0].ptw_status), 5);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_owner", 64'(owner), 0);
      tick();
      rst_i   = 1'b0;
      req_vec = '0;
      ptw_in  = '0;
      @(negedge clk);
      chk("idle_orphan", 64'(orphan), 0);
      chk("idle_fwd_valid", 64'(fwd_out.req.valid), 0);

      // Single client, same-cycle forward, response 3 cycles later.
      tick();
      set_req(1, 1'b1, 27'h12345);
      ptw_in.ptw_ready = 1'b1;
      push(EV_ACC, 1, 32'h12345);
      @(negedge clk);
      chk("s1_fwd_vpn", 64'(fwd_out.req.vpn), 64'h12345);
      chk("s1_ready_c0", 64'(cli_view[0].ptw_ready), 0);
      tick();
      set_req(1, 1'b0, 27'h0);
      ptw_in.ptw_ready = 1'b0;
      @(negedge clk);
      chk("s1_busy", 64'(busy), 1);
      chk("s1_owner", 64'(owner), 1);
      tick();
      tick();
      ptw_in.resp.valid = 1'b1;
      ptw_in.resp.pte   = 32'hA5A5_0001;
      push(EV_RESP, 1, 32'hA5A5_0001);
      @(negedge clk);
      chk("s1_resp_c0", 64'(cli_view[0].resp.valid), 0);
      tick();
      ptw_in.resp = '0;
      @(negedge clk);
      chk("s1_busy_after", 64'(busy), 0);
      chk("s1_owner_held", 64'(owner), 1);

      // Both clients valid: grant order 0,1,0,1 and one idle busy cycle between walks.
      tick();
      set_req(0, 1'b1, 27'h0AAA);
      set_req(1, 1'b1, 27'h0BBB);
      ptw_in.ptw_ready = 1'b1;
      for (int w = 0; w < 4; w++) begin
         push(EV_ACC, w % 2, (w % 2 == 1) ? 32'h0BBB : 32'h0AAA);
         @(negedge clk);
         chk("s2_busy_gap", 64'(busy), 0);
         chk("s2_fwd_vpn", 64'(fwd_out.req.vpn), (w % 2 == 1) ? 64'h0BBB : 64'h0AAA);
         tick();
         @(negedge clk);
         chk("s2_busy_wait", 64'(busy), 1);
         chk("s2_fwd_in_wait", 64'(fwd_out.req.valid), 0);
         tick();
         ptw_in.resp.valid = 1'b1;
         ptw_in.resp.pte   = 32'h2000 + 32'(w);
         push(EV_RESP, w % 2, 32'h2000 + 32'(w));
         @(negedge clk);
         chk("s2_no_grant_resp_cycle", 64'(fwd_out.req.valid), 0);
         tick();
         ptw_in.resp = '0;
         if (w == 3) begin
            req_vec          = '0;
            ptw_in.ptw_ready = 1'b0;
         end
      end

      // Grant lock: client1 held while client0 raises valid.
      set_req(1, 1'b1, 27'h3333);
      for (int c = 0; c < 4; c++) begin
         if (c == 2) set_req(0, 1'b1, 27'h0444);
         @(negedge clk);
         chk("s3_locked_vpn", 64'(fwd_out.req.vpn), 64'h3333);
         chk("s3_busy", 64'(busy), 0);
         tick();
      end
      ptw_in.ptw_ready = 1'b1;
      push(EV_ACC, 1, 32'h3333);
      @(negedge clk);
      chk("s3_accept_vpn", 64'(fwd_out.req.vpn), 64'h3333);
      chk("s3_ready_c0", 64'(cli_view[0].ptw_ready), 0);
      tick();
      set_req(1, 1'b0, 27'h0);
      ptw_in.ptw_ready = 1'b0;
      tick();
      ptw_in.resp.valid = 1'b1;
      ptw_in.resp.pte   = 32'h0000_3003;
      push(EV_RESP, 1, 32'h0000_3003);
      tick();
      ptw_in.resp = '0;

      // Cancel: client0 locked then withdrawn under invalidate; client1 then granted.
      set_req(1, 1'b1, 27'h5555);
      @(negedge clk);
      chk("s4_grant_c0", 64'(fwd_out.req.vpn), 64'h0444);
      tick();
      ptw_in.invalidate_tlb = 1'b1;
      set_req(0, 1'b0, 27'h0);
      @(negedge clk);
      chk("s4_cancel_fwd", 64'(fwd_out.req.valid), 0);
      chk("s4_inval_c0", 64'(cli_view[0].invalidate_tlb), 1);
      chk("s4_inval_c1", 64'(cli_view[1].invalidate_tlb), 1);
      tick();
      ptw_in.invalidate_tlb = 1'b0;
      ptw_in.ptw_ready      = 1'b1;
      push(EV_ACC, 1, 32'h5555);
      @(negedge clk);
      chk("s4_regrant_vpn", 64'(fwd_out.req.vpn), 64'h5555);
      tick();
      set_req(1, 1'b0, 27'h0);
      ptw_in.ptw_ready = 1'b0;

      // Invalidate during WAIT: response still reaches the owner.
      ptw_in.invalidate_tlb = 1'b1;
      @(negedge clk);
      chk("s5_busy_inval", 64'(busy), 1);
      chk("s5_inval_c1", 64'(cli_view[1].invalidate_tlb), 1);
      tick();
      ptw_in.invalidate_tlb = 1'b0;
      tick();
      ptw_in.resp.valid = 1'b1;
      ptw_in.resp.pte   = 32'h0000_CAFE;
      push(EV_RESP, 1, 32'h0000_CAFE);
      @(negedge clk);
      chk("s5_resp_c0", 64'(cli_view[0].resp.valid), 0);
      tick();
      ptw_in.resp = '0;
      @(negedge clk);
      chk("s5_idle", 64'(busy), 0);

      // Reset mid-walk, then a late response is an orphan.
      tick();
      set_req(1, 1'b1, 27'h0666);
      ptw_in.ptw_ready = 1'b1;
      push(EV_ACC, 1, 32'h0666);
      @(negedge clk);
      tick();
      set_req(1, 1'b0, 27'h0);
      ptw_in.ptw_ready = 1'b0;
      rst_i = 1'b1;
      @(negedge clk);
      chk("s6_owner_pre_rst", 64'(owner), 1);
      tick();
      rst_i = 1'b0;
      ptw_in.resp.valid = 1'b1;
      ptw_in.resp.pte   = 32'h0000_DEAD;
      push(EV_ORPH, 0, 32'h0);
      @(negedge clk);
      chk("s6_orphan", 64'(orphan), 1);
      chk("s6_busy_rst", 64'(busy), 0);
      chk("s6_owner_rst", 64'(owner), 0);
      chk("s6_resp_c1", 64'(cli_view[1].resp.valid), 0);
      tick();
      ptw_in.resp = '0;
      @(negedge clk);
      chk("s6_orphan_pulse", 64'(orphan), 0);

      // Orphan while GRANTED leaves the lock intact.
      tick();
      set_req(0, 1'b1, 27'h0777);
      @(negedge clk);
      chk("s7_fwd_vpn", 64'(fwd_out.req.vpn), 64'h0777);
      tick();
      ptw_in.resp.valid = 1'b1;
      ptw_in.resp.pte   = 32'h0000_BEEF;
      push(EV_ORPH, 0, 32'h0);
      @(negedge clk);
      chk("s7_orphan", 64'(orphan), 1);
      chk("s7_still_locked", 64'(fwd_out.req.vpn), 64'h0777);
      chk("s7_resp_c0", 64'(cli_view[0].resp.valid), 0);
      tick();
      ptw_in.resp      = '0;
      ptw_in.ptw_ready = 1'b1;
      push(EV_ACC, 0, 32'h0777);
      tick();
      set_req(0, 1'b0, 27'h0);
      ptw_in.ptw_ready = 1'b0;
      tick();
      ptw_in.resp.valid = 1'b1;
      ptw_in.resp.pte   = 32'h0000_0007;
      push(EV_RESP, 0, 32'h0000_0007);
      tick();
      ptw_in.resp = '0;
      tick();
      @(negedge clk);
      chk("sb_empty", 64'(sb_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
